// File: rtl/crc8_frame_checker.sv
// Receive-side CRC-8 frame checker: parses [LEN][payload x LEN][CRC] frames,
// forwards payload bytes and issues a one-cycle verdict strobe per frame.
module crc8_frame_checker #(
    parameter int          MAX_LEN = 16,
    parameter int          TIMEOUT = 1000,
    parameter logic [7:0]  POLY    = 8'h07
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        clear,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_first,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [1:0]  err_code,
    output logic [15:0] good_count,
    output logic [15:0] bad_count,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } state_t;

    localparam logic [7:0]  MAX_B   = 8'(MAX_LEN);
    localparam logic [31:0] TO_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_CRC  = 2'd1;
    localparam logic [1:0] ERR_LEN  = 2'd2;
    localparam logic [1:0] ERR_TO   = 2'd3;

    state_t      state;
    logic [7:0]  crc;
    logic [7:0]  remaining;
    logic [31:0] idle_cnt;
    logic        first_pending;

    // One full byte of MSB-first CRC-8, eight shift steps unrolled.
    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] x;
        x = c ^ b;
        for (int i = 0; i < 8; i++) begin
            x = x[7] ? ((x << 1) ^ POLY) : (x << 1);
        end
        return x;
    endfunction

    assign dbg_state = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            crc           <= 8'h00;
            remaining     <= 8'h00;
            idle_cnt      <= 32'd0;
            first_pending <= 1'b0;
            out_data      <= 8'h00;
            out_valid     <= 1'b0;
            out_first     <= 1'b0;
            frame_done    <= 1'b0;
            frame_ok      <= 1'b0;
            err_code      <= ERR_NONE;
            good_count    <= 16'h0000;
            bad_count     <= 16'h0000;
        end else begin
            out_valid  <= 1'b0;
            out_first  <= 1'b0;
            frame_done <= 1'b0;
            if (clear) begin
                state         <= IDLE;
                crc           <= 8'h00;
                remaining     <= 8'h00;
                idle_cnt      <= 32'd0;
                first_pending <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (in_valid) begin
                            if (in_data == 8'h00 || in_data > MAX_B) begin
                                // Stay in IDLE so the next byte is tried as LEN (resync).
                                frame_done <= 1'b1;
                                frame_ok   <= 1'b0;
                                err_code   <= ERR_LEN;
                                if (bad_count != 16'hFFFF) bad_count <= bad_count + 16'd1;
                            end else begin
                                crc           <= crc_step(8'h00, in_data);
                                remaining     <= in_data;
                                idle_cnt      <= 32'd0;
                                first_pending <= 1'b1;
                                state         <= PAYLOAD;
                            end
                        end
                    end
                    PAYLOAD, CHECK: begin
                        if (in_valid) begin
                            idle_cnt <= 32'd0;
                            if (state == PAYLOAD) begin
                                crc           <= crc_step(crc, in_data);
                                out_data      <= in_data;
                                out_valid     <= 1'b1;
                                out_first     <= first_pending;
                                first_pending <= 1'b0;
                                remaining     <= remaining - 8'd1;
                                if (remaining == 8'd1) state <= CHECK;
                            end else begin
                                frame_done <= 1'b1;
                                frame_ok   <= (in_data == crc);
                                err_code   <= (in_data == crc) ? ERR_NONE : ERR_CRC;
                                if (in_data == crc) begin
                                    if (good_count != 16'hFFFF) good_count <= good_count + 16'd1;
                                end else begin
                                    if (bad_count != 16'hFFFF) bad_count <= bad_count + 16'd1;
                                end
                                crc   <= 8'h00;
                                state <= IDLE;
                            end
                        end else if (TIMEOUT != 0 && idle_cnt == TO_LAST) begin
                            // This idle cycle is the TIMEOUT-th in a row: abort the frame.
                            frame_done <= 1'b1;
                            frame_ok   <= 1'b0;
                            err_code   <= ERR_TO;
                            if (bad_count != 16'hFFFF) bad_count <= bad_count + 16'd1;
                            crc        <= 8'h00;
                            remaining  <= 8'h00;
                            idle_cnt   <= 32'd0;
                            state      <= IDLE;
                        end else if (TIMEOUT != 0) begin
                            idle_cnt <= idle_cnt + 32'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
